// File: rtl/rs422_frame_packer_pkg.sv
// Shared types and constants for the RS-422 frame packer: FSM states, header bytes
// and frame-length helper.
package rs422_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EMIT     = 2'd1,
      WAIT_ACK = 2'd2,
      GAP      = 2'd3
   } state_e;

   localparam logic [7:0] HDR0_DEFAULT = 8'hEB;
   localparam logic [7:0] HDR1_DEFAULT = 8'h90;

   // Byte index register width; covers frames up to 255 bytes.
   localparam int IDX_W = 8;

   // Header (2) + sequence (1) + payload (2 per word) + checksum (1).
   function automatic int frame_bytes(input int words);
      return 2 * words + 4;
   endfunction

endpackage

// File: rtl/rs422_sample_fifo.sv
// Synchronous sample FIFO with first-word-visible read: the head word is always
// presented on rd_data so the packer can load it on the same edge it pops.
module rs422_sample_fifo
   import rs422_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_sample,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_sample) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_sample) begin
      if (do_push) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/rs422_frame_packer.sv
// Packs buffered 16-bit samples into header/seq/payload/checksum byte frames and
// hands them one byte at a time to the UART send stage with a strobe/ack handshake.
module rs422_frame_packer
   import rs422_pkg::*;
#(
   parameter int         WORDS       = 4,
   parameter int         FIFO_DEPTH  = 8,
   parameter int         DR_WIDTH    = 15,
   parameter int         ACK_TIMEOUT = 1023,
   parameter logic [7:0] HDR0        = HDR0_DEFAULT,
   parameter logic [7:0] HDR1        = HDR1_DEFAULT
) (
   input  logic        clk_sample,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   input  logic        tx_ack,
   output logic        data_ready,
   output logic [7:0]  tx_byte,
   output logic        frame_busy,
   output logic        overflow,
   output logic        abort,
   output logic [7:0]  seq
);

   localparam int FB    = frame_bytes(WORDS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int DR_W  = $clog2(DR_WIDTH + 1);
   localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

   localparam logic [IDX_W-1:0] IDX_HDR1 = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_SEQ  = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FB - 1);
   localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DR_WIDTH - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WORDS_C  = CNT_W'(WORDS);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DR_W-1:0]  dr_cnt_q, dr_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             data_ready_q, data_ready_d;
   logic             frame_busy_q, frame_busy_d;
   logic [7:0]       seq_q, seq_d;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       hold_q, hold_d;
   logic             abort_q, abort_d;
   logic             overflow_q, overflow_d;

   logic             fifo_pop;
   logic [15:0]      fifo_rd_data;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   rs422_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk_sample (clk_sample),
      .rst        (rst),
      .push       (sample_valid),
      .pop        (fifo_pop),
      .wr_data    (sample_data),
      .rd_data    (fifo_rd_data),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dr_cnt_d     = dr_cnt_q;
      to_cnt_d     = to_cnt_q;
      tx_byte_d    = tx_byte_q;
      data_ready_d = data_ready_q;
      frame_busy_d = frame_busy_q;
      seq_d        = seq_q;
      csum_d       = csum_q;
      hold_d       = hold_q;
      abort_d      = 1'b0;
      overflow_d   = overflow_q;
      fifo_pop     = 1'b0;

      case (state_q)
         IDLE: begin
            if (fifo_count >= WORDS_C) begin
               state_d      = EMIT;
               frame_busy_d = 1'b1;
               idx_d        = '0;
               tx_byte_d    = HDR0;
               data_ready_d = 1'b1;
               dr_cnt_d     = '0;
               csum_d       = '0;
            end
         end

         EMIT: begin
            // tx_ack is deliberately not looked at while the strobe is up.
            if (dr_cnt_q == DR_LAST) begin
               state_d      = WAIT_ACK;
               data_ready_d = 1'b0;
               to_cnt_d     = '0;
            end else begin
               dr_cnt_d = dr_cnt_q + DR_W'(1);
            end
         end

         WAIT_ACK: begin
            if (tx_ack) begin
               if (idx_q == IDX_LAST) begin
                  state_d      = IDLE;
                  frame_busy_d = 1'b0;
                  seq_d        = seq_q + 8'd1;
               end else begin
                  state_d = GAP;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end else if (to_cnt_q == TO_LAST) begin
               state_d      = IDLE;
               frame_busy_d = 1'b0;
               abort_d      = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end

         GAP: begin
            state_d      = EMIT;
            data_ready_d = 1'b1;
            dr_cnt_d     = '0;
            // Payload MSB bytes sit at odd indices; the checksum index is odd too, so test it first.
            if (idx_q == IDX_HDR1) begin
               tx_byte_d = HDR1;
            end else if (idx_q == IDX_SEQ) begin
               tx_byte_d = seq_q;
               csum_d    = seq_q;
            end else if (idx_q == IDX_LAST) begin
               tx_byte_d = csum_q;
            end else if (idx_q[0]) begin
               fifo_pop  = !fifo_empty;
               tx_byte_d = fifo_rd_data[15:8];
               hold_d    = fifo_rd_data[7:0];
               csum_d    = csum_q + fifo_rd_data[15:8];
            end else begin
               tx_byte_d = hold_q;
               csum_d    = csum_q + hold_q;
            end
         end

         default: state_d = IDLE;
      endcase

      if (sample_valid && fifo_full && !fifo_pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk_sample) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         dr_cnt_q     <= '0;
         to_cnt_q     <= '0;
         tx_byte_q    <= '0;
         data_ready_q <= 1'b0;
         frame_busy_q <= 1'b0;
         seq_q        <= '0;
         csum_q       <= '0;
         hold_q       <= '0;
         abort_q      <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         dr_cnt_q     <= dr_cnt_d;
         to_cnt_q     <= to_cnt_d;
         tx_byte_q    <= tx_byte_d;
         data_ready_q <= data_ready_d;
         frame_busy_q <= frame_busy_d;
         seq_q        <= seq_d;
         csum_q       <= csum_d;
         hold_q       <= hold_d;
         abort_q      <= abort_d;
         overflow_q   <= overflow_d;
      end
   end

   assign data_ready = data_ready_q;
   assign tx_byte    = tx_byte_q;
   assign frame_busy = frame_busy_q;
   assign overflow   = overflow_q;
   assign abort      = abort_q;
   assign seq        = seq_q;

endmodule

// File: tb/tb_rs422_frame_packer.sv
// Directed bench for rs422_frame_packer: frame contents, strobe width, ack handling,
// timeout abort, overflow, back-to-back frames, seq wrap and mid-frame reset.
module tb_rs422_frame_packer;

   localparam int DR_WIDTH = 15;

   logic        clk_sample = 1'b0;
   logic        rst;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        tx_ack;
   logic        data_ready;
   logic [7:0]  tx_byte;
   logic        frame_busy;
   logic        overflow;
   logic        abort;
   logic [7:0]  seq;

   int pass_cnt  = 0;
   int total_cnt = 0;

   rs422_frame_packer dut (
      .clk_sample   (clk_sample),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .tx_ack       (tx_ack),
      .data_ready   (data_ready),
      .tx_byte      (tx_byte),
      .frame_busy   (frame_busy),
      .overflow     (overflow),
      .abort        (abort),
      .seq          (seq)
   );

   always #5 clk_sample = ~clk_sample;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [95:0] make_frame(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c, input logic [15:0] d,
                                              input logic [7:0] s);
      logic [7:0] cs;
      cs = s + a[15:8] + a[7:0] + b[15:8] + b[7:0] + c[15:8] + c[7:0] + d[15:8] + d[7:0];
      return {8'hEB, 8'h90, s, a, b, c, d, cs};
   endfunction

   // Called at a falling edge; returns at the falling edge after the push edge.
   task automatic push_word(input logic [15:0] w);
      sample_valid = 1'b1;
      sample_data  = w;
      @(negedge clk_sample);
      sample_valid = 1'b0;
   endtask

   // Waits for a strobe, measures it, optionally pokes tx_ack mid-strobe, then acks
   // ack_delay cycles after the strobe drops (no ack when ack_delay < 0).
   task automatic recv_byte(input int ack_delay, input bit mid_ack,
                            output logic [7:0] b, output int hi, output int waited);
      bit stable;
      waited = 0;
      while (!data_ready && waited < 3000) begin
         @(negedge clk_sample);
         waited++;
      end
      check("dr_seen", 32'(data_ready), 1);
      b      = tx_byte;
      hi     = 0;
      stable = 1'b1;
      while (data_ready && hi < 64) begin
         tx_ack = (mid_ack && hi == 5);
         if (tx_byte !== b) stable = 1'b0;
         hi++;
         @(negedge clk_sample);
      end
      tx_ack = 1'b0;
      check("byte_stable", 32'(stable), 1);
      if (ack_delay >= 0) begin
         repeat (ack_delay) @(negedge clk_sample);
         tx_ack = 1'b1;
         @(negedge clk_sample);
         tx_ack = 1'b0;
      end
   endtask

   task automatic run_frame(input logic [95:0] exp, input int ack_delay,
                            input int mid_byte, input int first_wait);
      logic [7:0] b;
      int         hi;
      int         waited;
      for (int i = 0; i < 12; i++) begin
         recv_byte(ack_delay, (i == mid_byte), b, hi, waited);
         check($sformatf("byte%0d", i), 32'(b), 32'(exp[95-8*i -: 8]));
         check($sformatf("dr_width%0d", i), hi, DR_WIDTH);
         if (i == 0 && first_wait >= 0) check("start_latency", waited, first_wait);
         check($sformatf("busy_after_ack%0d", i), 32'(frame_busy), (i == 11) ? 0 : 1);
      end
      $display("frame seq=%02h bytes=%h", exp[71:64], exp);
   endtask

   task automatic expect_quiet(input string tag, input int n);
      bit seen;
      seen = 1'b0;
      repeat (n) begin
         if (data_ready) seen = 1'b1;
         @(negedge clk_sample);
      end
      check(tag, 32'(seen), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  b;
      logic [7:0]  exp_seq;
      logic [95:0] exp;
      logic [15:0] w [4];
      int          hi;
      int          waited;
      int          cnt;

      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_data  = '0;
      tx_ack       = 1'b0;
      repeat (3) @(negedge clk_sample);
      check("rst_data_ready", 32'(data_ready), 0);
      check("rst_tx_byte", 32'(tx_byte), 0);
      check("rst_frame_busy", 32'(frame_busy), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_abort", 32'(abort), 0);
      check("rst_seq", 32'(seq), 0);
      rst = 1'b0;
      @(negedge clk_sample);

      // Reference frame, acks three cycles after each strobe.
      push_word(16'h1234);
      push_word(16'h5678);
      push_word(16'h9ABC);
      push_word(16'hDEF0);
      run_frame(96'hEB90_0012_3456_789A_BCDE_F038, 3, -1, 1);
      check("seq_after_f1", 32'(seq), 1);

      // Ack pulsed during the strobe of byte 5 must be ignored.
      push_word(16'h0102);
      push_word(16'h0304);
      push_word(16'hA0B0);
      push_word(16'hFFFF);
      run_frame(make_frame(16'h0102, 16'h0304, 16'hA0B0, 16'hFFFF, 8'h01), 2, 5, 1);
      check("seq_after_f2", 32'(seq), 2);

      // Ack timeout on byte 4 (LSB of the first word, which was already popped).
      push_word(16'h1111);
      push_word(16'h2222);
      push_word(16'h3333);
      push_word(16'h4444);
      exp = make_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 8'h02);
      for (int i = 0; i < 4; i++) begin
         recv_byte(1, 1'b0, b, hi, waited);
         check($sformatf("abort_frame_byte%0d", i), 32'(b), 32'(exp[95-8*i -: 8]));
      end
      recv_byte(-1, 1'b0, b, hi, waited);
      check("abort_frame_byte4", 32'(b), 32'h11);
      cnt = 0;
      while (!abort && cnt < 1100) begin
         @(negedge clk_sample);
         cnt++;
      end
      check("abort_latency", cnt, 1023);
      check("abort_busy", 32'(frame_busy), 0);
      check("abort_seq", 32'(seq), 2);
      @(negedge clk_sample);
      check("abort_one_cycle", 32'(abort), 0);
      expect_quiet("abort_idle", 20);
      push_word(16'h5555);
      run_frame(make_frame(16'h2222, 16'h3333, 16'h4444, 16'h5555, 8'h02), 1, -1, 1);
      check("seq_after_abort_resend", 32'(seq), 3);

      // Nine pushes in a row: the ninth is dropped; two frames follow back to back.
      fork
         for (int k = 0; k < 9; k++) push_word({8'hC0, 8'(k)});
         begin
            run_frame(make_frame(16'hC000, 16'hC001, 16'hC002, 16'hC003, 8'h03), 0, -1, -1);
            check("overflow_set", 32'(overflow), 1);
            run_frame(make_frame(16'hC004, 16'hC005, 16'hC006, 16'hC007, 8'h04), 0, -1, 1);
         end
      join
      check("overflow_sticky_b2b", 32'(overflow), 1);
      check("seq_after_b2b", 32'(seq), 5);
      push_word(16'h0D01);
      push_word(16'h0D02);
      push_word(16'h0D03);
      expect_quiet("ninth_dropped", 20);
      push_word(16'h0D04);
      run_frame(make_frame(16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04, 8'h05), 0, -1, 1);

      // Run on until the sequence number wraps.
      exp_seq = 8'd6;
      for (int f = 0; f < 250; f++) begin
         for (int k = 0; k < 4; k++) begin
            w[k] = {8'(f), 8'(k * 37 + f)};
            push_word(w[k]);
         end
         run_frame(make_frame(w[0], w[1], w[2], w[3], exp_seq), 0, -1, 1);
         exp_seq = exp_seq + 8'd1;
      end
      check("seq_wrap", 32'(seq), 0);
      check("overflow_sticky_wrap", 32'(overflow), 1);

      // Reset in the middle of the payload.
      push_word(16'h7001);
      push_word(16'h7002);
      push_word(16'h7003);
      push_word(16'h7004);
      for (int i = 0; i < 4; i++) recv_byte(1, 1'b0, b, hi, waited);
      waited = 0;
      while (!data_ready && waited < 100) begin
         @(negedge clk_sample);
         waited++;
      end
      check("pre_reset_strobe", 32'(data_ready), 1);
      rst = 1'b1;
      @(negedge clk_sample);
      check("midrst_data_ready", 32'(data_ready), 0);
      check("midrst_frame_busy", 32'(frame_busy), 0);
      check("midrst_seq", 32'(seq), 0);
      check("midrst_overflow", 32'(overflow), 0);
      check("midrst_tx_byte", 32'(tx_byte), 0);
      rst = 1'b0;
      expect_quiet("post_reset_idle", 30);
      push_word(16'h8001);
      push_word(16'h8002);
      push_word(16'h8003);
      expect_quiet("fifo_flushed", 20);
      push_word(16'h8004);
      run_frame(make_frame(16'h8001, 16'h8002, 16'h8003, 16'h8004, 8'h00), 1, -1, 1);
      check("seq_after_reset_frame", 32'(seq), 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
